axi4_lite_regfile: RTL and testbench
====================================

AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bus width; only 32 supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: subordinate byte-address width; 2^(ADDR_WIDTH-2) >= REG_COUNT.
REQ-003 SHALL have parameter REG_COUNT, default 4: number of WIDTH-bit registers.
REQ-004 SHALL have parameter RESET_VALUE, default 0: value loaded into every register on reset.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on posedge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port axi_s, axi4_lite interface (WIDTH, ADDR_WIDTH), subordinate side: drives awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp; samples all other signals.
REQ-008 SHALL have port reg_out, output, REG_COUNT x WIDTH: current register contents.
REQ-009 SHALL have port wr_pulse, output, REG_COUNT: one-cycle pulse per register on write commit.

Function
REQ-010 SHALL decode word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored; index >= REG_COUNT is out of range.
REQ-011 SHALL capture AW and W independently; either order, or the same cycle.
REQ-012 SHALL assert awready while no AW is held and bvalid=0; SHALL deassert it the cycle after the AW handshake.
REQ-013 SHALL assert wready while no W is held and bvalid=0; SHALL deassert it the cycle after the W handshake.
REQ-014 SHALL commit the write on the edge where both AW and W are held or handshaking; bvalid=1 from the next cycle.
REQ-015 SHALL apply wstrb byte-wise on commit; bytes with a strobe bit of 0 keep their old value.
REQ-016 SHALL set bresp=OKAY for an in-range commit; out-of-range: SLVERR, no register changes, no wr_pulse.
REQ-017 SHALL hold bvalid and bresp stable until bready; on the bvalid&&bready edge SHALL clear bvalid, clear AW/W held, and reassert awready/wready next cycle.
REQ-018 SHALL pulse wr_pulse[index] for exactly the cycle in which reg_out shows the new value.
REQ-019 SHALL assert arready while rvalid=0; on arvalid&&arready SHALL register rdata/rresp, set rvalid=1 next cycle, arready=0.
REQ-020 SHALL return rdata=register, rresp=OKAY for in range; rdata=0, rresp=SLVERR out of range.
REQ-021 SHALL hold rvalid, rdata, rresp stable until rready; on rvalid&&rready SHALL clear rvalid and set arready=1 next cycle.
REQ-022 SHALL run read and write paths concurrently; at most one outstanding transaction each.
REQ-023 SHALL, when AR and a write commit on the same edge to the same register, return the pre-write value.
REQ-024 SHALL keep throughput at one write per 2 cycles minimum with bready held high.
REQ-025 SHALL keep throughput at one read per 2 cycles minimum with rready held high.
REQ-026 SHALL never assert bvalid without a completed AW and W.
REQ-027 SHALL never assert rvalid without a completed AR.

Reset
REQ-028 SHALL, on rst=1 at posedge, set all registers to RESET_VALUE and drop held AW/W.
REQ-029 SHALL, on rst=1 at posedge, set bvalid=rvalid=0, bresp=rresp=OKAY, rdata=0, wr_pulse=0.
REQ-030 SHALL drive awready=wready=arready=0 during reset; all three =1 the first cycle after rst falls.
REQ-031 SHALL abandon any in-flight transaction on reset mid-operation; no late response is issued.

Verification
REQ-032 Write 0xDEADBEEF to 0x4, wstrb=0xF, AW and W same cycle -> bvalid next cycle, bresp=OKAY, reg_out[1]=0xDEADBEEF, wr_pulse=0b0010 one cycle.
REQ-033 W (0x12345678, wstrb=0x3) 3 cycles before AW 0x8, reg2 initially 0xAAAAAAAA -> reg_out[2]=0xAAAA5678 one cycle after AW handshake.
REQ-034 Read 0x4 after REQ-032, rready low 4 cycles -> rvalid=1, rdata=0xDEADBEEF stable throughout, arready=0 until handshake.
REQ-035 Write and read to 0xC (REG_COUNT=4, so 0xC is in range) vs 0x10 with ADDR_WIDTH=5 -> 0x10: bresp=SLVERR, rresp=SLVERR, rdata=0, no reg change.
REQ-036 AR 0x0 same edge as write commit 0x0 of 0x55 (old 0x0) -> rdata=0x0; subsequent read returns 0x55.
REQ-037 rst asserted while bvalid=1 and bready=0 -> bvalid=0 next edge, all reg_out=RESET_VALUE, no bvalid after rst falls.

Source files
------------

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle for the register file.
// Parameters: WIDTH (data width), ADDR_WIDTH (byte-address width).
// Channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
// Modports: master drives requests and response-ready; slave drives the rest.
interface axi4_lite_regfile_if #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [WIDTH-1:0]      wdata;
   logic [WIDTH/8-1:0]    wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [WIDTH-1:0]      rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite subordinate exposing REG_COUNT word registers.
// Ports: clk, rst (sync, active-high), axi_s (slave side of the bus),
//        reg_out (current register contents), wr_pulse (one-cycle per-register
//        strobe aligned with the new value appearing on reg_out).
// AW and W are captured independently; the write commits on the edge where both
// are present. Reads and writes proceed concurrently, one outstanding each.
module axi4_lite_regfile #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      ADDR_WIDTH  = 4,
   parameter int unsigned      REG_COUNT   = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   axi4_lite_regfile_if.slave              axi_s,
   output logic [REG_COUNT-1:0][WIDTH-1:0] reg_out,
   output logic [REG_COUNT-1:0]            wr_pulse
);

   localparam int unsigned STRB_W      = WIDTH / 8;
   localparam int unsigned IDX_W       = ADDR_WIDTH - 2;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic [REG_COUNT-1:0][WIDTH-1:0] regs_q, regs_d;
   logic                            aw_held_q, aw_held_d;
   logic [IDX_W-1:0]                aw_idx_q, aw_idx_d;
   logic                            w_held_q, w_held_d;
   logic [WIDTH-1:0]                w_data_q, w_data_d;
   logic [STRB_W-1:0]               w_strb_q, w_strb_d;
   logic                            bvalid_q, bvalid_d;
   logic [1:0]                      bresp_q, bresp_d;
   logic [REG_COUNT-1:0]            wr_pulse_q, wr_pulse_d;
   logic                            rvalid_q, rvalid_d;
   logic [WIDTH-1:0]                rdata_q, rdata_d;
   logic [1:0]                      rresp_q, rresp_d;

   logic              aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]  wr_idx, ar_idx;
   logic [WIDTH-1:0]  wr_data;
   logic [STRB_W-1:0] wr_strb;
   logic              wr_in_range;
   logic              unused_addr_lsbs;

   // Ready flags derive from held state; forced low while reset is asserted.
   assign axi_s.awready = !rst && !aw_held_q && !bvalid_q;
   assign axi_s.wready  = !rst && !w_held_q && !bvalid_q;
   assign axi_s.arready = !rst && !rvalid_q;
   assign axi_s.bvalid  = bvalid_q;
   assign axi_s.bresp   = bresp_q;
   assign axi_s.rvalid  = rvalid_q;
   assign axi_s.rdata   = rdata_q;
   assign axi_s.rresp   = rresp_q;
   assign reg_out       = regs_q;
   assign wr_pulse      = wr_pulse_q;

   assign aw_hs  = axi_s.awvalid && axi_s.awready;
   assign w_hs   = axi_s.wvalid && axi_s.wready;
   assign ar_hs  = axi_s.arvalid && axi_s.arready;
   assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

   // Use the held beat if one was captured earlier, else the one handshaking now.
   assign wr_idx      = aw_held_q ? aw_idx_q : axi_s.awaddr[ADDR_WIDTH-1:2];
   assign wr_data     = w_held_q ? w_data_q : axi_s.wdata;
   assign wr_strb     = w_held_q ? w_strb_q : axi_s.wstrb;
   assign wr_in_range = 32'(wr_idx) < REG_COUNT;
   assign ar_idx      = axi_s.araddr[ADDR_WIDTH-1:2];

   // Byte-offset bits do not take part in decoding.
   assign unused_addr_lsbs = ^{axi_s.awaddr[1:0], axi_s.araddr[1:0]};

   // Next-state for the write path, read path and register array.
   always_comb begin
      regs_d     = regs_q;
      aw_held_d  = aw_held_q;
      aw_idx_d   = aw_idx_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = axi_s.awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = axi_s.wdata;
         w_strb_d = axi_s.wstrb;
      end

      // Held beats are consumed at commit; bvalid then blocks new beats.
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (wr_in_range && (32'(wr_idx) == i)) begin
               wr_pulse_d[i] = 1'b1;
               for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) begin
                     regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                  end
               end
            end
         end
      end else if (bvalid_q && axi_s.bready) begin
         bvalid_d = 1'b0;
      end

      // Read samples regs_q, so a same-edge write returns the old contents.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = RESP_SLVERR;
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (32'(ar_idx) == i) begin
               rdata_d = regs_q[i];
               rresp_d = RESP_OKAY;
            end
         end
      end else if (rvalid_q && axi_s.rready) begin
         rvalid_d = 1'b0;
      end
   end

   // State register; reset abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q     <= {REG_COUNT{RESET_VALUE}};
         aw_held_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         regs_q     <= regs_d;
         aw_held_q  <= aw_held_d;
         aw_idx_q   <= aw_idx_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Self-checking bench for axi4_lite_regfile (ADDR_WIDTH=5, REG_COUNT=4).
// Responses are checked by a negedge monitor against queues of expectations
// pushed when each request is driven.
module tb_axi4_lite_regfile;

   localparam int unsigned AW = 5;
   localparam int unsigned NV = 13;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [31:0]   data;   // write data, or expected read data
      logic [3:0]    strb;
      logic [1:0]    resp;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [3:0][31:0] reg_out;
   logic [3:0]       wr_pulse;

   always #5 clk = ~clk;

   axi4_lite_regfile_if #(.WIDTH(32), .ADDR_WIDTH(AW)) bus ();

   axi4_lite_regfile #(
      .WIDTH(32), .ADDR_WIDTH(AW), .REG_COUNT(4), .RESET_VALUE(32'h0)
   ) dut (
      .clk(clk), .rst(rst), .axi_s(bus), .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [1:0]  wr_exp_q[$];
   rd_exp_t     rd_exp_q[$];
   logic [31:0] exp_regs[4];
   vec_t        vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s reg_out[%0d]", tag, i), reg_out[i], exp_regs[i]);
   endtask

   // Response monitor: a handshake visible at negedge completes at the next posedge.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.bvalid && bus.bready) begin
            if (wr_exp_q.size() == 0) check("unexpected_bvalid", 32'(bus.bvalid), 32'd0);
            else begin
               logic [1:0] e;
               e = wr_exp_q.pop_front();
               check("bresp", 32'(bus.bresp), 32'(e));
            end
         end
         if (bus.rvalid && bus.rready) begin
            if (rd_exp_q.size() == 0) check("unexpected_rvalid", 32'(bus.rvalid), 32'd0);
            else begin
               rd_exp_t r;
               r = rd_exp_q.pop_front();
               check("rdata", bus.rdata, r.data);
               check("rresp", 32'(bus.rresp), 32'(r.resp));
            end
         end
      end
   end

   // AW and W presented together; bready held high.
   task automatic write_txn(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
      bit aw_pend, w_pend, aw_go, w_go;
      int n, idx;
      logic [3:0] exp_pulse;
      aw_pend = 1'b1; w_pend = 1'b1; n = 0;
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb; bus.bready = 1'b1;
      wr_exp_q.push_back(exp_resp);
      while ((aw_pend || w_pend) && n < 20) begin
         bus.awvalid = aw_pend; bus.wvalid = w_pend;
         aw_go = aw_pend && bus.awready;
         w_go  = w_pend && bus.wready;
         tick();
         if (aw_go) aw_pend = 1'b0;
         if (w_go)  w_pend  = 1'b0;
         n++;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("wr_accept_cycles", 32'(n), 32'd1);
      idx = int'(addr[AW-1:2]);
      exp_pulse = '0;
      if (idx < 4) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) exp_regs[idx][8*b +: 8] = data[8*b +: 8];
         exp_pulse[idx] = 1'b1;
      end
      check("bvalid_after_commit", 32'(bus.bvalid), 32'd1);
      check("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
      check_regs("wr");
      tick();
      check("bvalid_cleared", 32'(bus.bvalid), 32'd0);
      check("wr_pulse_one_cycle", 32'(wr_pulse), 32'd0);
   endtask

   task automatic read_txn(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
      rd_exp_t r;
      bit go;
      int n;
      r.data = exp_data; r.resp = exp_resp;
      rd_exp_q.push_back(r);
      bus.araddr = addr; bus.rready = 1'b1;
      go = 1'b0; n = 0;
      while (!go && n < 20) begin
         bus.arvalid = 1'b1;
         go = bus.arready;
         tick();
         n++;
      end
      bus.arvalid = 1'b0;
      check("rd_accept_cycles", 32'(n), 32'd1);
      check("rvalid_after_ar", 32'(bus.rvalid), 32'd1);
      tick();
      check("rvalid_cleared", 32'(bus.rvalid), 32'd0);
      check("arready_back", 32'(bus.arready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rd_exp_t r;
      vecs[0]  = '{1'b1, 5'h0C, 32'h11223344, 4'hF, 2'b00};
      vecs[1]  = '{1'b0, 5'h0C, 32'h11223344, 4'h0, 2'b00};
      vecs[2]  = '{1'b1, 5'h10, 32'hFFFFFFFF, 4'hF, 2'b10};
      vecs[3]  = '{1'b0, 5'h10, 32'h00000000, 4'h0, 2'b10};
      vecs[4]  = '{1'b1, 5'h1C, 32'h01010101, 4'hF, 2'b10};
      vecs[5]  = '{1'b0, 5'h1C, 32'h00000000, 4'h0, 2'b10};
      vecs[6]  = '{1'b1, 5'h05, 32'hCAFE0000, 4'hC, 2'b00};
      vecs[7]  = '{1'b0, 5'h07, 32'hCAFEBEEF, 4'h0, 2'b00};
      vecs[8]  = '{1'b1, 5'h08, 32'hFFFFFFFF, 4'h0, 2'b00};
      vecs[9]  = '{1'b0, 5'h08, 32'hAAAA5678, 4'h0, 2'b00};
      vecs[10] = '{1'b0, 5'h0C, 32'h11223344, 4'h0, 2'b00};
      vecs[11] = '{1'b1, 5'h0E, 32'h0000EE00, 4'h2, 2'b00};
      vecs[12] = '{1'b0, 5'h0D, 32'h1122EE44, 4'h0, 2'b00};

      for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
      rst = 1'b1;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;

      // Reset state
      tick(); tick();
      check("rst awready", 32'(bus.awready), 32'd0);
      check("rst wready", 32'(bus.wready), 32'd0);
      check("rst arready", 32'(bus.arready), 32'd0);
      check("rst bvalid", 32'(bus.bvalid), 32'd0);
      check("rst rvalid", 32'(bus.rvalid), 32'd0);
      check("rst bresp", 32'(bus.bresp), 32'd0);
      check("rst rresp", 32'(bus.rresp), 32'd0);
      check("rst rdata", bus.rdata, 32'd0);
      check("rst wr_pulse", 32'(wr_pulse), 32'd0);
      check_regs("rst");
      rst = 1'b0;
      #1;
      check("post-rst readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

      // AW and W together
      write_txn(5'h04, 32'hDEADBEEF, 4'hF, 2'b00);

      // Read held with rready low for 4 cycles
      r.data = 32'hDEADBEEF; r.resp = 2'b00;
      rd_exp_q.push_back(r);
      bus.araddr = 5'h04; bus.rready = 1'b0; bus.arvalid = 1'b1;
      check("arready before AR", 32'(bus.arready), 32'd1);
      tick();
      bus.arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("stall rvalid", 32'(bus.rvalid), 32'd1);
         check("stall rdata", bus.rdata, 32'hDEADBEEF);
         check("stall arready", 32'(bus.arready), 32'd0);
         tick();
      end
      bus.rready = 1'b1;
      tick();
      check("stall rvalid cleared", 32'(bus.rvalid), 32'd0);
      check("stall arready back", 32'(bus.arready), 32'd1);

      // W three cycles ahead of AW, partial strobe
      write_txn(5'h08, 32'hAAAAAAAA, 4'hF, 2'b00);
      wr_exp_q.push_back(2'b00);
      bus.wdata = 32'h12345678; bus.wstrb = 4'h3; bus.wvalid = 1'b1; bus.bready = 1'b1;
      check("early W wready", 32'(bus.wready), 32'd1);
      tick();
      bus.wvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("W held wready", 32'(bus.wready), 32'd0);
         check("W held bvalid", 32'(bus.bvalid), 32'd0);
         check("W held awready", 32'(bus.awready), 32'd1);
         check("W held reg2", reg_out[2], 32'hAAAAAAAA);
         tick();
      end
      bus.awaddr = 5'h08; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      exp_regs[2] = 32'hAAAA5678;
      check("late AW bvalid", 32'(bus.bvalid), 32'd1);
      check("late AW reg2", reg_out[2], 32'hAAAA5678);
      check("late AW wr_pulse", 32'(wr_pulse), 32'h4);
      tick();

      // AR and write commit on the same edge to the same register
      wr_exp_q.push_back(2'b00);
      r.data = 32'h0; r.resp = 2'b00;
      rd_exp_q.push_back(r);
      bus.awaddr = 5'h00; bus.wdata = 32'h55; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.araddr = 5'h00; bus.arvalid = 1'b1;
      bus.bready = 1'b1; bus.rready = 1'b1;
      check("collide readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      exp_regs[0] = 32'h55;
      check("collide rdata old", bus.rdata, 32'h0);
      check("collide reg0", reg_out[0], 32'h55);
      tick();
      read_txn(5'h00, 32'h55, 2'b00);

      // Table-driven vectors
      for (int i = 0; i < int'(NV); i++) begin
         if (vecs[i].wr) write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
         else            read_txn(vecs[i].addr, vecs[i].data, vecs[i].resp);
      end
      check_regs("table end");

      // Reset while both responses are stalled
      wr_exp_q.push_back(2'b00);
      r.data = 32'h1122EE44; r.resp = 2'b00;
      rd_exp_q.push_back(r);
      bus.bready = 1'b0; bus.rready = 1'b0;
      bus.awaddr = 5'h0C; bus.wdata = 32'h99999999; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.araddr = 5'h0C; bus.arvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      tick();
      check("stalled bvalid", 32'(bus.bvalid), 32'd1);
      check("stalled bresp", 32'(bus.bresp), 32'd0);
      check("stalled rdata pre-write", bus.rdata, 32'h1122EE44);
      check("stalled reg3", reg_out[3], 32'h99999999);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
      wr_exp_q.delete();
      rd_exp_q.delete();
      check("mid-rst bvalid", 32'(bus.bvalid), 32'd0);
      check("mid-rst rvalid", 32'(bus.rvalid), 32'd0);
      check("mid-rst readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h0);
      check("mid-rst wr_pulse", 32'(wr_pulse), 32'd0);
      check_regs("mid-rst");
      rst = 1'b0;
      bus.bready = 1'b1; bus.rready = 1'b1;
      #1;
      check("after mid-rst readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            seen = seen | bus.bvalid | bus.rvalid;
            tick();
         end
         check("no late response", 32'(seen), 32'd0);
      end

      check("wr queue drained", 32'(wr_exp_q.size()), 32'd0);
      check("rd queue drained", 32'(rd_exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
